vc_ingress_router: RTL and testbench

Ingress side of the transmission layer. It accepts a single 6-bit word stream from upstream and classifies each word by its class bit. It then writes each word into the VC0 or VC1 FIFO, whose read side feeds the arbitration/routing stage. A 2-entry holding buffer absorbs VC back-pressure, and upstream sees a ready/push handshake.

---
 rtl/vc_ingress_router_pkg.sv | 24 ++
 rtl/vc_ingress_router_if.sv | 32 +++
 rtl/vc_ingress_router_hold_buffer.sv | 57 +++++
 rtl/vc_ingress_router.sv | 118 +++++++++++
 tb/tb_vc_ingress_router.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/vc_ingress_router_pkg.sv
// Shared constants and FSM encoding for the VC ingress router.
// The head word's class bit picks which VC FIFO receives it.
package vc_ingress_router_pkg;

  localparam int DATA_WIDTH = 6;
  localparam int CLASS_BIT  = 5;
  localparam int BUF_DEPTH  = 2;
  localparam int CNT_WIDTH  = 8;
  localparam int OCC_WIDTH  = $clog2(BUF_DEPTH) + 1;

  localparam logic VC0_SEL = 1'b0;
  localparam logic VC1_SEL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_STALL  = 2'b10
  } state_t;

  function automatic logic vc_paused(input logic vc, input logic af_vc0, input logic af_vc1);
    return (vc == VC1_SEL) ? af_vc1 : af_vc0;
  endfunction

endpackage

// File: rtl/vc_ingress_router_if.sv
// Upstream word handshake plus both VC FIFO write ports.
// The slave view belongs to the router; the master view drives it.
interface vc_ingress_router_if;
  import vc_ingress_router_pkg::*;

  logic [DATA_WIDTH-1:0] data_in;
  logic                  push_in;
  logic                  ready_out;
  logic                  almost_full_VC0;
  logic                  almost_full_VC1;
  logic                  push_VC0;
  logic                  push_VC1;
  logic [DATA_WIDTH-1:0] data_in_VC0;
  logic [DATA_WIDTH-1:0] data_in_VC1;
  logic                  error_in;
  logic [CNT_WIDTH-1:0]  count_VC0;
  logic [CNT_WIDTH-1:0]  count_VC1;
  logic                  idle;

  modport slave (
    input  data_in, push_in, almost_full_VC0, almost_full_VC1,
    output ready_out, push_VC0, push_VC1, data_in_VC0, data_in_VC1,
           error_in, count_VC0, count_VC1, idle
  );

  modport master (
    output data_in, push_in, almost_full_VC0, almost_full_VC1,
    input  ready_out, push_VC0, push_VC1, data_in_VC0, data_in_VC1,
           error_in, count_VC0, count_VC1, idle
  );

endinterface

// File: rtl/vc_ingress_router_hold_buffer.sv
// Small synchronous FIFO holding words until their VC can take them.
// Writes when full and reads when empty are ignored.
module vc_hold_buffer #(
  parameter int DW    = 6,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     i_wr,
  input  logic [DW-1:0]            i_wr_data,
  input  logic                     i_rd,
  output logic [DW-1:0]            o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_wr = i_wr & ~o_full;
  assign w_rd = i_rd & ~o_empty;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/vc_ingress_router.sv
// Classifies upstream words by class bit and dispatches them in order
// to the VC0/VC1 FIFOs, holding up to BUF_DEPTH words under back-pressure.
//   state  | meaning
//   IDLE   | buffer empty, nothing in flight
//   ACTIVE | head dispatchable or buffer filling
//   STALL  | head blocked by its VC's almost_full
module vc_ingress_router
  import vc_ingress_router_pkg::*;
(
  input  logic              clk,
  input  logic              reset_L,
  vc_ingress_router_if.slave bus
);

  logic [DATA_WIDTH-1:0] w_head;
  logic [OCC_WIDTH-1:0]  w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_head_vc;
  logic                  w_paused;
  logic                  w_dispatch;
  logic                  w_occ_next_zero;
  state_t                w_state_next;

  state_t                r_state;
  logic                  r_push_vc0;
  logic                  r_push_vc1;
  logic [DATA_WIDTH-1:0] r_data_vc0;
  logic [DATA_WIDTH-1:0] r_data_vc1;
  logic                  r_error;
  logic [CNT_WIDTH-1:0]  r_cnt_vc0;
  logic [CNT_WIDTH-1:0]  r_cnt_vc1;

  // Ready comes from registered occupancy only, so a full buffer never
  // accepts on the same edge its head leaves.
  assign w_ready    = ~w_full;
  assign w_accept   = bus.push_in & w_ready;
  assign w_head_vc  = w_head[CLASS_BIT];
  assign w_paused   = vc_paused(w_head_vc, bus.almost_full_VC0, bus.almost_full_VC1);
  assign w_dispatch = ~w_empty & ~w_paused;

  assign w_occ_next_zero = ~w_accept &
                           (w_empty | ((w_count == OCC_WIDTH'(1)) & w_dispatch));

  vc_hold_buffer #(
    .DW    (DATA_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_hold_buffer (
    .clk       (clk),
    .reset_L   (reset_L),
    .i_wr      (w_accept),
    .i_wr_data (bus.data_in),
    .i_rd      (w_dispatch),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (~w_empty & w_paused) w_state_next = ST_STALL;
        else if (w_occ_next_zero) w_state_next = ST_IDLE;
      end
      ST_STALL: begin
        if (~w_paused) w_state_next = ST_ACTIVE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_push_vc0 <= 1'b0;
      r_push_vc1 <= 1'b0;
      r_data_vc0 <= '0;
      r_data_vc1 <= '0;
      r_error    <= 1'b0;
      r_cnt_vc0  <= '0;
      r_cnt_vc1  <= '0;
    end else begin
      r_push_vc0 <= w_dispatch & (w_head_vc == VC0_SEL);
      r_push_vc1 <= w_dispatch & (w_head_vc == VC1_SEL);
      r_error    <= bus.push_in & ~w_ready;
      if (w_dispatch && (w_head_vc == VC0_SEL)) begin
        r_data_vc0 <= w_head;
        r_cnt_vc0  <= r_cnt_vc0 + 1'b1;
      end
      if (w_dispatch && (w_head_vc == VC1_SEL)) begin
        r_data_vc1 <= w_head;
        r_cnt_vc1  <= r_cnt_vc1 + 1'b1;
      end
    end
  end

  assign bus.ready_out   = w_ready;
  assign bus.push_VC0    = r_push_vc0;
  assign bus.push_VC1    = r_push_vc1;
  assign bus.data_in_VC0 = r_data_vc0;
  assign bus.data_in_VC1 = r_data_vc1;
  assign bus.error_in    = r_error;
  assign bus.count_VC0   = r_cnt_vc0;
  assign bus.count_VC1   = r_cnt_vc1;
  assign bus.idle        = (r_state == ST_IDLE) & ~r_push_vc0 & ~r_push_vc1;

endmodule

// File: tb/tb_vc_ingress_router.sv
// Bench for vc_ingress_router: a queue-based model predicts every output
// each cycle, plus literal expectations for the directed scenarios.
module tb_vc_ingress_router;
  import vc_ingress_router_pkg::*;

  logic clk = 1'b0;
  logic reset_L = 1'b0;

  vc_ingress_router_if bus();

  vc_ingress_router dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [5:0] mq[$];
  logic       m_push0, m_push1, m_err;
  logic [5:0] m_d0, m_d1;
  logic [7:0] m_c0, m_c1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_push0 = 1'b0; m_push1 = 1'b0; m_err = 1'b0;
    m_d0 = '0; m_d1 = '0; m_c0 = '0; m_c1 = '0;
  endtask

  // One clock edge of the reference behaviour, from the pre-edge state.
  task automatic model_edge(input logic p, input logic [5:0] d, input logic a0, input logic a1);
    logic       rdy;
    logic [5:0] h;
    logic       blocked;
    rdy = (mq.size() < BUF_DEPTH);
    m_push0 = 1'b0;
    m_push1 = 1'b0;
    if (mq.size() > 0) begin
      h = mq[0];
      blocked = h[5] ? a1 : a0;
      if (!blocked) begin
        void'(mq.pop_front());
        if (h[5]) begin m_push1 = 1'b1; m_d1 = h; m_c1 = m_c1 + 8'd1; end
        else      begin m_push0 = 1'b1; m_d0 = h; m_c0 = m_c0 + 8'd1; end
      end
    end
    m_err = p && !rdy;
    if (p && rdy) mq.push_back(d);
  endtask

  task automatic compare_all();
    chk("ready_out",   bus.ready_out,   mq.size() < BUF_DEPTH);
    chk("push_VC0",    bus.push_VC0,    m_push0);
    chk("push_VC1",    bus.push_VC1,    m_push1);
    chk("data_in_VC0", bus.data_in_VC0, m_d0);
    chk("data_in_VC1", bus.data_in_VC1, m_d1);
    chk("error_in",    bus.error_in,    m_err);
    chk("count_VC0",   bus.count_VC0,   m_c0);
    chk("count_VC1",   bus.count_VC1,   m_c1);
    chk("idle",        bus.idle,        (mq.size() == 0) && !m_push0 && !m_push1);
    chk("push_excl",   bus.push_VC0 & bus.push_VC1, 1'b0);
  endtask

  task automatic step(input logic p, input logic [5:0] d, input logic a0, input logic a1);
    bus.push_in = p;
    bus.data_in = d;
    bus.almost_full_VC0 = a0;
    bus.almost_full_VC1 = a1;
    model_edge(p, d, a0, a1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    bus.push_in = 1'b0;
    bus.data_in = '0;
    bus.almost_full_VC0 = 1'b0;
    bus.almost_full_VC1 = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_L = 1'b1;
    compare_all();
    chk("rst_ready", bus.ready_out, 1'b1);
    chk("rst_idle",  bus.idle,      1'b1);
    chk("rst_cnt0",  bus.count_VC0, 8'd0);

    // Three words, no pause
    step(1'b1, 6'h05, 1'b0, 1'b0);
    step(1'b1, 6'h21, 1'b0, 1'b0);
    chk("t1_push0_a", bus.push_VC0,    1'b1);
    chk("t1_data0_a", bus.data_in_VC0, 6'h05);
    step(1'b1, 6'h0A, 1'b0, 1'b0);
    chk("t1_push1",   bus.push_VC1,    1'b1);
    chk("t1_data1",   bus.data_in_VC1, 6'h21);
    chk("t1_push0_b", bus.push_VC0,    1'b0);
    step(1'b0, 6'h00, 1'b0, 1'b0);
    chk("t1_push0_c", bus.push_VC0,    1'b1);
    chk("t1_data0_c", bus.data_in_VC0, 6'h0A);
    step(1'b0, 6'h00, 1'b0, 1'b0);
    chk("t1_cnt0", bus.count_VC0, 8'd2);
    chk("t1_cnt1", bus.count_VC1, 8'd1);
    chk("t1_idle", bus.idle,      1'b1);

    // VC1 paused: fill, overflow, head-of-line blocking
    step(1'b1, 6'h30, 1'b0, 1'b1);
    step(1'b1, 6'h01, 1'b0, 1'b1);
    chk("t2_not_ready", bus.ready_out, 1'b0);
    step(1'b1, 6'h02, 1'b0, 1'b1);
    chk("t2_err",       bus.error_in,  1'b1);
    chk("t2_ready",     bus.ready_out, 1'b0);
    step(1'b0, 6'h00, 1'b0, 1'b1);
    chk("t2_err_clr",   bus.error_in,  1'b0);
    chk("t2_blocked0",  bus.push_VC0,  1'b0);
    step(1'b0, 6'h00, 1'b0, 1'b0);
    chk("t2_first_p",   bus.push_VC1,    1'b1);
    chk("t2_first_d",   bus.data_in_VC1, 6'h30);
    step(1'b0, 6'h00, 1'b0, 1'b0);
    chk("t2_second_p",  bus.push_VC0,    1'b1);
    chk("t2_second_d",  bus.data_in_VC0, 6'h01);
    step(1'b0, 6'h00, 1'b0, 1'b0);
    step(1'b0, 6'h00, 1'b0, 1'b0);

    // Continuous push, VC0 pause toggling every 3 cycles
    for (int i = 0; i < 60; i++)
      step(1'b1, 6'($urandom), 1'(((i / 3) % 2)), 1'b0);
    repeat (4) step(1'b0, 6'h00, 1'b0, 1'b0);

    // Fully random traffic and pauses
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 6'($urandom),
           1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 3));
    repeat (4) step(1'b0, 6'h00, 1'b0, 1'b0);

    // Reset mid-stream with two words held behind pauses
    step(1'b1, 6'h11, 1'b1, 1'b1);
    step(1'b1, 6'h22, 1'b1, 1'b1);
    chk("t4_full", bus.ready_out, 1'b0);
    bus.push_in = 1'b0;
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("t4_arst_cnt0", bus.count_VC0, 8'd0);
    chk("t4_arst_rdy",  bus.ready_out, 1'b1);
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    step(1'b0, 6'h00, 1'b0, 1'b0);
    chk("t4_no_push0", bus.push_VC0,  1'b0);
    chk("t4_no_push1", bus.push_VC1,  1'b0);
    chk("t4_ready",    bus.ready_out, 1'b1);

    // 256 words to VC0: counter wraps
    for (int i = 0; i < 256; i++)
      step(1'b1, 6'($urandom_range(0, 31)), 1'b0, 1'b0);
    repeat (3) step(1'b0, 6'h00, 1'b0, 1'b0);
    chk("t5_cnt0_wrap", bus.count_VC0, 8'd0);
    chk("t5_cnt1_zero", bus.count_VC1, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
